// File: rtl/dfi_init_sequencer_if.sv
// rtl/dfi_init_sequencer_if.sv - DFI init handshake pair between the init sequencer and the PHY
interface dfi_init_sequencer_if;
  logic dfi_init_start;
  logic dfi_init_complete;

  modport master (
    output dfi_init_start,
    input  dfi_init_complete
  );

  modport slave (
    input  dfi_init_start,
    output dfi_init_complete
  );
endinterface

// File: rtl/dfi_init_sequencer.sv
// rtl/dfi_init_sequencer.sv - LPDDR4 PHY bring-up over the DFI init handshake with debounce and timeout
// Optional automatic retry with backoff when DFI_INIT_AUTO_RETRY_EN is defined.
module dfi_init_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int MAX_RETRIES     = 3,
  parameter int BACKOFF_CYCLES  = 16,
  parameter int HB_DIV_LOG2     = 26
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_req,
  dfi_init_sequencer_if.master        dfi,
  output logic                        busy,
  output logic                        done,
  output logic                        fail,
  output logic [1:0]                  fail_code,
  output logic [1:0]                  retry_cnt,
  output logic                        heartbeat
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_MAX - 1);

`ifdef DFI_INIT_AUTO_RETRY_EN
  localparam logic [TMR_W-1:0] BO_LAST     = TMR_W'(BACKOFF_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_ACK,
    S_WAIT_CPL,
    S_DONE,
    S_FAIL
`ifdef DFI_INIT_AUTO_RETRY_EN
    ,
    S_BACKOFF
`endif
  } state_t;

  state_t state, state_nx;

  logic [1:0]             start_sync;
  logic [1:0]             cpl_sync;
  logic                   start_s;
  logic                   cpl_s;
  logic [DB_W-1:0]        db_cnt;
  logic                   db_stable;
  logic                   db_stable_q;
  logic                   start_evt;
  logic [TMR_W-1:0]       timer;
  logic                   timeout;
  logic [HB_DIV_LOG2-1:0] hb_cnt;
  logic                   start_q;

  logic                   start_nx;
  logic                   busy_nx;
  logic                   done_nx;
  logic                   fail_nx;
  logic [1:0]             code_nx;
  logic [1:0]             retry_nx;
  logic                   tmo_hit;
  logic [1:0]             tmo_code;

  assign start_s   = start_sync[1];
  assign cpl_s     = cpl_sync[1];
  assign start_evt = db_stable & ~db_stable_q;
  assign timeout   = (timer == TMO_LAST);

  assign dfi.dfi_init_start = start_q;
  assign heartbeat          = hb_cnt[HB_DIV_LOG2-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync <= 2'b00;
      cpl_sync   <= 2'b00;
    end else begin
      start_sync <= {start_sync[0], start_req};
      cpl_sync   <= {cpl_sync[0], dfi.dfi_init_complete};
    end
  end

  // Counter runs only while the synced input disagrees with the accepted level,
  // so any bounce back to the accepted level restarts the qualification window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt      <= '0;
      db_stable   <= 1'b0;
      db_stable_q <= 1'b0;
    end else begin
      db_stable_q <= db_stable;
      if (start_s == db_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_stable <= start_s;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt <= '0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      start_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      retry_cnt <= 2'd0;
    end else begin
      state     <= state_nx;
      start_q   <= start_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      fail      <= fail_nx;
      fail_code <= code_nx;
      retry_cnt <= retry_nx;
      if (state_nx != state) begin
        timer <= '0;
      end else if (timer != TMR_LAST) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = fail_code;
    retry_nx = retry_cnt;
    tmo_hit  = 1'b0;
    tmo_code = 2'd0;

    // Synchronised complete edges are tested before the timeout so progress wins a tie.
    case (state)
      S_IDLE: begin
        if (start_evt) state_nx = S_ASSERT;
      end
      S_ASSERT: begin
        state_nx = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!cpl_s) begin
          state_nx = S_WAIT_CPL;
        end else if (timeout) begin
          tmo_hit  = 1'b1;
          tmo_code = 2'd1;
        end
      end
      S_WAIT_CPL: begin
        if (cpl_s) begin
          state_nx = S_DONE;
        end else if (timeout) begin
          tmo_hit  = 1'b1;
          tmo_code = 2'd2;
        end
      end
      S_DONE: begin
        if (start_evt) begin
          state_nx = S_ASSERT;
          code_nx  = 2'd0;
          retry_nx = 2'd0;
        end else if (!cpl_s) begin
          state_nx = S_FAIL;
          code_nx  = 2'd3;
        end
      end
      S_FAIL: begin
        if (start_evt) begin
          state_nx = S_ASSERT;
          code_nx  = 2'd0;
          retry_nx = 2'd0;
        end
      end
`ifdef DFI_INIT_AUTO_RETRY_EN
      S_BACKOFF: begin
        if (timer == BO_LAST) state_nx = S_ASSERT;
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (tmo_hit) begin
`ifdef DFI_INIT_AUTO_RETRY_EN
      if (retry_cnt < RETRY_LIMIT) begin
        state_nx = S_BACKOFF;
        retry_nx = retry_cnt + 2'd1;
      end else begin
        state_nx = S_FAIL;
        code_nx  = tmo_code;
      end
`else
      state_nx = S_FAIL;
      code_nx  = tmo_code;
`endif
    end

`ifndef DFI_INIT_AUTO_RETRY_EN
    retry_nx = 2'd0;
`endif

    start_nx = (state_nx == S_ASSERT) || (state_nx == S_WAIT_ACK) || (state_nx == S_WAIT_CPL);
    busy_nx  = start_nx;
`ifdef DFI_INIT_AUTO_RETRY_EN
    busy_nx  = start_nx || (state_nx == S_BACKOFF);
`endif
    done_nx  = (state_nx == S_DONE);
    fail_nx  = (state_nx == S_FAIL);
  end

endmodule
